dmem_lsu_ctrl: RTL and testbench
================================

Name: dmem_lsu_ctrl

Overview:
- Load/store sequencer between the RV32 core's memory stage and the word-wide data memory (single port, synchronous write, registered read address).
- Accepts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests over a valid/ready handshake and drives the word-addressed RAM port.
- Performs sub-word stores as read-modify-write, and performs load byte-lane extraction plus sign/zero extension.
- Returns one response per request, with a misalignment error flag.

Parameters:
- ADDR_W, 18, byte-address width; RAM word address is ADDR_W-2 bits (16).
- DATA_W, 32, data width; fixed at 32. Any other value is unsupported.

Ports:
- sysCLK  in  1  system clock, rising edge
- resetN  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  zero-extend load (LBU/LHU); ignored for stores and words
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned access or illegal size
- mem_addr  out  ADDR_W-2  RAM word address
- mem_wdata  out  32  RAM write data
- mem_we  out  1  RAM write enable
- mem_rdata  in  32  RAM read data; reflects the address registered on the previous edge

Behaviour:
- All outputs are registered. On reset: state IDLE; req_ready=1; resp_valid=0, resp_err=0; resp_rdata=0, mem_addr=0, mem_wdata=0, mem_we=0.
- States: IDLE, RD, CAP, WR, RESP.
- IDLE: a request is accepted when req_valid && req_ready. The controller latches we, size, unsigned, addr, wdata; mem_addr <= addr[ADDR_W-1:2].
- Error check at accept time: size==11, or half with addr[0]=1, or word with addr[1:0]!=0 -> go to RESP with resp_err=1 and resp_rdata=0. No RAM access occurs and mem_we stays 0.
- Word store: IDLE -> WR. In WR, mem_we=1 and mem_wdata=wdata for exactly one cycle. Then -> RESP.
- Load: IDLE -> RD -> CAP. In CAP, mem_rdata is valid; resp_rdata <= extracted lane. Then -> RESP.
- Sub-word store: IDLE -> RD -> CAP. In CAP, mem_wdata <= mem_rdata with the selected lane replaced by wdata[7:0] or wdata[15:0]. Then -> WR -> RESP.
- Lanes are little-endian. Byte lane = addr[1:0] (bits 8*k+7:8*k). Half lane = addr[1] (bits 15:0 or 31:16).
- Extension: sign-extend from bit 7 or 15 unless unsigned=1, in which case zero-extend.
- mem_addr is constant from accept until return to IDLE, and holds its last value in IDLE.
- RESP: resp_valid=1, with resp_rdata/resp_err stable until resp_ready. Exit on resp_valid && resp_ready: resp_valid <= 0, resp_err <= 0, -> IDLE. req_ready rises the same edge.
- A new request is accepted no earlier than the cycle after the response handshake. There is no overlap, so at most one transaction is in flight.
- Latency from accept edge to resp_valid, assuming resp_ready is held high:
  - error: 1 cycle
  - SW: 2 cycles
  - load: 3 cycles
  - SB/SH: 4 cycles
- req_* inputs are ignored outside IDLE.
- Asserting resetN low mid-transaction:
  - returns to IDLE asynchronously and forces mem_we=0 immediately;
  - drops the transaction without a response;
  - a partial RMW never writes (WR has not been reached, or its write edge is suppressed).
- Writes to the RAM occur only in WR. Exactly one RAM write occurs per successful store; zero occur for loads and errors.

Test Plan:
- SW addr 0x0010, wdata 0xDEADBEEF; then LW 0x0010 -> mem_we pulses once with mem_addr=4; load response is resp_rdata=0xDEADBEEF, resp_err=0, 3 cycles after accept.
- Memory word 4 = 0xDEADBEEF; SB addr 0x0012, wdata 0x000000AA -> exactly one write with mem_wdata=0xDEAABEEF; response 4 cycles after accept.
- Word 4 = 0xDEAABEEF: LB 0x0012 -> 0xFFFFFFAA; LBU 0x0012 -> 0x000000AA; LH 0x0012 -> 0xFFFFDEAA; LHU 0x0010 -> 0x0000BEEF.
- LW 0x0011, SH 0x0013, and req_size=11 -> each gives resp_err=1, resp_rdata=0, 1-cycle latency, mem_we never asserted.
- LW 0x0010 with resp_ready held low for 5 cycles -> resp_valid and resp_rdata stay stable and req_ready=0 throughout. After the handshake, req_ready=1 on the next cycle, and a back-to-back request is then accepted.
- SB in flight with resetN pulsed low during CAP -> mem_we=0, state IDLE, no response, memory word unchanged; a subsequent LW returns the original value.

Source files
------------

// File: rtl/dmem_lsu_ctrl.sv
// ----------------------------------------------------------------------------
// dmem_lsu_ctrl
//
// Purpose:
//   Load/store sequencer between the RV32 memory stage and a single-port,
//   word-wide data RAM. The RAM writes synchronously and registers its read
//   address. The controller accepts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW
//   requests and returns one response per request. Sub-word stores are done
//   as read-modify-write. Loads get byte-lane extraction and sign/zero
//   extension. Misaligned accesses and the illegal size code are reported
//   with an error flag and never touch the RAM.
//
// Ports:
//   sysCLK        system clock, rising edge
//   resetN        asynchronous, active-low reset
//   req_valid     request present
//   req_ready     controller can accept a request (IDLE only)
//   req_we        1 = store, 0 = load
//   req_size      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  zero-extend sub-word loads
//   req_addr      byte address
//   req_wdata     store data, right-aligned
//   resp_valid    response available
//   resp_ready    consumer accepts response
//   resp_rdata    extended load data (0 for stores and errors)
//   resp_err      misaligned access or illegal size
//   mem_addr      RAM word address
//   mem_wdata     RAM write data
//   mem_we        RAM write enable
//   mem_rdata     RAM read data for the address registered on the last edge
// ----------------------------------------------------------------------------
module dmem_lsu_ctrl #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 32
) (
  input  logic              sysCLK,
  input  logic              resetN,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  logic [2:0]  r_state;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata;

  logic              w_accept;
  logic              w_reqErr;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_loadData;
  logic [DATA_W-1:0] w_merged;

  assign w_accept = (r_state == S_IDLE) && req_valid && req_ready;

  // Bytes can never be misaligned. Halves need addr[0]=0 and words need
  // addr[1:0]=0.
  assign w_reqErr = (req_size == SZ_BAD) ||
                    ((req_size == SZ_HALF) && req_addr[0]) ||
                    ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

  // Little-endian lane selection from the word that was just read.
  assign w_byte = mem_rdata[{r_lane, 3'b000} +: 8];
  assign w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    w_loadData = mem_rdata;
    case (r_size)
      SZ_BYTE: w_loadData = r_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_HALF: w_loadData = r_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_loadData = mem_rdata;
    endcase
  end

  // RMW merge: keep the rest of the old word and replace only the addressed lane.
  always_comb begin
    w_merged = mem_rdata;
    if (r_size == SZ_HALF) begin
      w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata;
    end else begin
      w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
    end
  end

  // Every output is driven straight from a register. mem_we is only ever set
  // on the edge that enters WR and cleared on the edge that leaves it, so an
  // asynchronous reset always cancels a pending write.
  always_ff @(posedge sysCLK or negedge resetN) begin
    if (!resetN) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_size     <= SZ_BYTE;
      r_unsigned <= 1'b0;
      r_lane     <= 2'b00;
      r_wdata    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_lane     <= req_addr[1:0];
            r_wdata    <= req_wdata[15:0];
            mem_addr   <= req_addr[ADDR_W-1:2];
            resp_rdata <= '0;
            req_ready  <= 1'b0;
            if (w_reqErr) begin
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              r_state    <= S_RESP;
            end else if (req_we && (req_size == SZ_WORD)) begin
              mem_wdata <= req_wdata;
              mem_we    <= 1'b1;
              r_state   <= S_WR;
            end else begin
              r_state <= S_RD;
            end
          end
        end
        S_RD: begin
          r_state <= S_CAP;
        end
        S_CAP: begin
          if (r_we) begin
            mem_wdata <= w_merged;
            mem_we    <= 1'b1;
            r_state   <= S_WR;
          end else begin
            resp_rdata <= w_loadData;
            resp_valid <= 1'b1;
            r_state    <= S_RESP;
          end
        end
        S_WR: begin
          mem_we     <= 1'b0;
          resp_valid <= 1'b1;
          r_state    <= S_RESP;
        end
        S_RESP: begin
          if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          mem_we     <= 1'b0;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dmem_lsu_ctrl
//
// Purpose:
//   Directed self-checking bench for dmem_lsu_ctrl. A small behavioural RAM
//   with a registered read address sits on the memory port. Every request's
//   response latency, data, error flag, word address and RAM write count is
//   compared against hand-computed values.
// ----------------------------------------------------------------------------
module tb_dmem_lsu_ctrl;

  localparam int ADDR_W = 18;

  logic              sysCLK = 1'b0;
  logic              resetN = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_unsigned = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic [31:0]       mem_rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] ram [0:63];
  logic [15:0] rdAddr = '0;
  int          wrCount = 0;
  logic [15:0] lastWrAddr = '0;
  logic [31:0] lastWrData = '0;

  dmem_lsu_ctrl #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .sysCLK       (sysCLK),
    .resetN       (resetN),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata)
  );

  always #5 sysCLK = ~sysCLK;

  // Behavioural RAM: synchronous write, registered read address.
  assign mem_rdata = ram[rdAddr[5:0]];

  always @(posedge sysCLK) begin
    if (mem_we === 1'b1) begin
      ram[mem_addr[5:0]] <= mem_wdata;
      wrCount    = wrCount + 1;
      lastWrAddr = mem_addr;
      lastWrData = mem_wdata;
    end
    rdAddr <= mem_addr;
  end

  // Watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one request when the controller is ready and holds it for the accept edge.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [17:0] addr, input logic [31:0] wdata);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(posedge sysCLK); #1;
      n++;
    end
    checkOutput("req_ready_before_accept", 32'(req_ready), 32'd1);
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    @(posedge sysCLK); #1;
    req_valid = 1'b0;
    req_wdata = 32'h5A5A_5A5A;
    checkOutput("req_ready_after_accept", 32'(req_ready), 32'd0);
  endtask

  // Counts edges from the accept edge (inclusive) until resp_valid is seen.
  task automatic waitResp(output int lat);
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 20) begin
      @(posedge sysCLK); #1;
      lat++;
    end
  endtask

  task automatic runTxn(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [17:0] addr, input logic [31:0] wdata, input int expLat,
                        input logic [31:0] expRdata, input logic expErr, input int expWrites);
    int w0;
    int lat;
    w0 = wrCount;
    applyStimulus(we, size, uns, addr, wdata);
    waitResp(lat);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_rdata"}, resp_rdata, expRdata);
    checkOutput({tag, "_err"}, 32'(resp_err), 32'(expErr));
    checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'(addr[17:2]));
    @(posedge sysCLK); #1;
    checkOutput({tag, "_resp_valid_drop"}, 32'(resp_valid), 32'd0);
    checkOutput({tag, "_req_ready_back"}, 32'(req_ready), 32'd1);
    checkOutput({tag, "_writes"}, 32'(wrCount - w0), 32'(expWrites));
  endtask

  initial begin
    int w0;
    int lat;
    for (int i = 0; i < 64; i++) ram[i] = 32'h0;

    // Reset state, both while held and after release.
    #12;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    @(negedge sysCLK);
    resetN = 1'b1;
    @(posedge sysCLK); #1;
    checkOutput("init_req_ready", 32'(req_ready), 32'd1);
    checkOutput("init_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("init_resp_err", 32'(resp_err), 32'd0);
    checkOutput("init_resp_rdata", resp_rdata, 32'd0);
    checkOutput("init_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("init_mem_wdata", mem_wdata, 32'd0);
    checkOutput("init_mem_we", 32'(mem_we), 32'd0);

    // Word store then word load.
    runTxn("sw_10", 1'b1, 2'b10, 1'b0, 18'h00010, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1);
    checkOutput("sw_10_wr_addr", 32'(lastWrAddr), 32'd4);
    checkOutput("sw_10_wr_data", lastWrData, 32'hDEADBEEF);
    runTxn("lw_10", 1'b0, 2'b10, 1'b0, 18'h00010, 32'h0, 3, 32'hDEADBEEF, 1'b0, 0);

    // Byte store as read-modify-write.
    runTxn("sb_12", 1'b1, 2'b00, 1'b0, 18'h00012, 32'h000000AA, 4, 32'h0, 1'b0, 1);
    checkOutput("sb_12_wr_addr", 32'(lastWrAddr), 32'd4);
    checkOutput("sb_12_wr_data", lastWrData, 32'hDEAABEEF);

    // Sub-word loads with sign and zero extension; word 4 = DEAABEEF.
    runTxn("lb_12",  1'b0, 2'b00, 1'b0, 18'h00012, 32'h0, 3, 32'hFFFFFFAA, 1'b0, 0);
    runTxn("lbu_12", 1'b0, 2'b00, 1'b1, 18'h00012, 32'h0, 3, 32'h000000AA, 1'b0, 0);
    runTxn("lh_12",  1'b0, 2'b01, 1'b0, 18'h00012, 32'h0, 3, 32'hFFFFDEAA, 1'b0, 0);
    runTxn("lhu_10", 1'b0, 2'b01, 1'b1, 18'h00010, 32'h0, 3, 32'h0000BEEF, 1'b0, 0);
    runTxn("lb_13",  1'b0, 2'b00, 1'b0, 18'h00013, 32'h0, 3, 32'hFFFFFFDE, 1'b0, 0);
    runTxn("lbu_11", 1'b0, 2'b00, 1'b1, 18'h00011, 32'h0, 3, 32'h000000BE, 1'b0, 0);

    // Half store into the upper lane of a zero word, then read it back.
    runTxn("sh_16", 1'b1, 2'b01, 1'b0, 18'h00016, 32'hFFFF1234, 4, 32'h0, 1'b0, 1);
    checkOutput("sh_16_wr_data", lastWrData, 32'h12340000);
    runTxn("lh_16", 1'b0, 2'b01, 1'b0, 18'h00016, 32'h0, 3, 32'h00001234, 1'b0, 0);

    // Errors: misaligned word, misaligned half store, illegal size.
    runTxn("err_lw_11", 1'b0, 2'b10, 1'b0, 18'h00011, 32'h0, 1, 32'h0, 1'b1, 0);
    runTxn("err_sh_13", 1'b1, 2'b01, 1'b0, 18'h00013, 32'h11112222, 1, 32'h0, 1'b1, 0);
    runTxn("err_size3", 1'b1, 2'b11, 1'b0, 18'h00010, 32'h33334444, 1, 32'h0, 1'b1, 0);
    checkOutput("err_word4_intact", ram[4], 32'hDEAABEEF);

    // Back-pressure: response held for 5 cycles, then a back-to-back request.
    resp_ready = 1'b0;
    applyStimulus(1'b0, 2'b10, 1'b0, 18'h00010, 32'h0);
    waitResp(lat);
    checkOutput("stall_latency", 32'(lat), 32'd3);
    checkOutput("stall_rdata", resp_rdata, 32'hDEAABEEF);
    for (int i = 0; i < 5; i++) begin
      @(posedge sysCLK); #1;
      checkOutput("stall_resp_valid", 32'(resp_valid), 32'd1);
      checkOutput("stall_rdata_hold", resp_rdata, 32'hDEAABEEF);
      checkOutput("stall_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge sysCLK); #1;
    checkOutput("stall_resp_valid_drop", 32'(resp_valid), 32'd0);
    checkOutput("stall_req_ready_back", 32'(req_ready), 32'd1);
    runTxn("b2b_lbu_10", 1'b0, 2'b00, 1'b1, 18'h00010, 32'h0, 3, 32'h000000EF, 1'b0, 0);

    // Reset pulsed while a byte store sits in CAP.
    w0 = wrCount;
    applyStimulus(1'b1, 2'b00, 1'b0, 18'h00010, 32'h00000055);
    @(posedge sysCLK); #1;
    resetN = 1'b0;
    #1;
    checkOutput("midrst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("midrst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("midrst_resp_valid", 32'(resp_valid), 32'd0);
    @(posedge sysCLK);
    @(negedge sysCLK);
    resetN = 1'b1;
    repeat (4) @(posedge sysCLK);
    #1;
    checkOutput("midrst_no_resp", 32'(resp_valid), 32'd0);
    checkOutput("midrst_no_write", 32'(wrCount - w0), 32'd0);
    checkOutput("midrst_word4", ram[4], 32'hDEAABEEF);
    runTxn("post_rst_lw", 1'b0, 2'b10, 1'b0, 18'h00010, 32'h0, 3, 32'hDEAABEEF, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
